// File: rtl/morse_tone_seq.sv
// morse_tone_seq: plays one Morse character as gap/tone phases timed in tick units.
module morse_tone_seq #(
  parameter int MAX_SYM = 5,
  parameter int LEN_W   = 4,
  parameter int LW      = $clog2(MAX_SYM + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               code_valid,
  output logic               code_ready,
  input  logic [MAX_SYM-1:0] code_bits,
  input  logic [LW-1:0]      code_len,
  input  logic [LEN_W-1:0]   dot_len,
  input  logic [LEN_W-1:0]   dash_len,
  input  logic [LEN_W-1:0]   gap_len,
  input  logic               abort,
  output logic               beep,
  output logic               busy,
  output logic               done,
  output logic [LW-1:0]      sym_idx
);
  typedef enum logic [1:0] {IDLE, GAP, TONE} state_t;
  state_t             state_q;
  logic [LEN_W-1:0]   cnt_q, dot_q, dash_q, gap_q;
  logic [LEN_W-1:0]   dot_d, dash_d, gap_d, tone_len;
  logic [MAX_SYM-1:0] bits_q;
  logic [LW-1:0]      len_q, sym_q, len_d;
  logic               beep_q, busy_q, done_q, accept, last, cur_bit;
  assign code_ready = state_q == IDLE;
  assign accept     = code_valid & code_ready & ~abort;
  assign len_d      = code_len > LW'(MAX_SYM) ? LW'(MAX_SYM) : code_len;
  // zero lengths are promoted to one tick at latch time
  assign dot_d      = dot_len  == '0 ? LEN_W'(1) : dot_len;
  assign dash_d     = dash_len == '0 ? LEN_W'(1) : dash_len;
  assign gap_d      = gap_len  == '0 ? LEN_W'(1) : gap_len;
  assign cur_bit    = |(bits_q & (MAX_SYM'(1) << sym_q));
  assign tone_len   = cur_bit ? dash_q : dot_q;
  assign last       = sym_q == len_q - LW'(1);
  assign beep       = beep_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sym_idx    = sym_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dot_q   <= '0;
      dash_q  <= '0;
      gap_q   <= '0;
      bits_q  <= '0;
      len_q   <= '0;
      sym_q   <= '0;
      beep_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sym_q   <= '0;
      beep_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (accept) begin
          bits_q <= code_bits;
          len_q  <= len_d;
          dot_q  <= dot_d;
          dash_q <= dash_d;
          gap_q  <= gap_d;
          sym_q  <= '0;
          if (len_d == '0) begin
            done_q <= 1'b1;
          end else begin
            state_q <= GAP;
            busy_q  <= 1'b1;
            cnt_q   <= gap_d - LEN_W'(1);
          end
        end
      end else if (tick) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - LEN_W'(1);
        end else if (state_q == GAP) begin
          state_q <= TONE;
          beep_q  <= 1'b1;
          cnt_q   <= tone_len - LEN_W'(1);
        end else if (!last) begin
          state_q <= GAP;
          beep_q  <= 1'b0;
          sym_q   <= sym_q + LW'(1);
          cnt_q   <= gap_q - LEN_W'(1);
        end else begin
          state_q <= IDLE;
          beep_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          sym_q   <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_morse_tone_seq.sv
// tb_morse_tone_seq: directed stimulus with a done-triggered beep-trace scoreboard.
module tb_morse_tone_seq;
  logic clk = 0, rst = 1, tick = 0, code_valid = 0, abort = 0;
  logic code_ready, beep, busy, done;
  logic [4:0] code_bits = 0;
  logic [2:0] code_len = 0, sym_idx;
  logic [3:0] dot_len = 0, dash_len = 0, gap_len = 0;
  typedef struct { logic [1023:0] tr; int n; } exp_t;
  exp_t q[$];
  int checks = 0, fails = 0;
  logic [1023:0] cap_tr = 0;
  int cap_n = 0;

  morse_tone_seq dut (.clk(clk), .rst(rst), .tick(tick), .code_valid(code_valid),
    .code_ready(code_ready), .code_bits(code_bits), .code_len(code_len),
    .dot_len(dot_len), .dash_len(dash_len), .gap_len(gap_len), .abort(abort),
    .beep(beep), .busy(busy), .done(done), .sym_idx(sym_idx));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // monitor: collects beep per busy cycle, compares against the queue head on each done
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("trace_len", cap_n, e.n);
        chk("trace_bits", int'(cap_tr == e.tr), 1);
      end
      cap_tr = 0;
      cap_n = 0;
    end else if (!busy) begin
      cap_tr = 0;
      cap_n = 0;
    end else begin
      cap_tr = {cap_tr[1022:0], beep};
      cap_n++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t expand(input logic [4:0] b, input int l, input int dl, input int dh,
                                  input int g, input int p);
    exp_t e;
    int ln, gl, tl;
    e.tr = 0;
    e.n = 0;
    ln = l > 5 ? 5 : l;
    gl = g == 0 ? 1 : g;
    for (int i = 0; i < ln; i++) begin
      tl = b[i] ? (dh == 0 ? 1 : dh) : (dl == 0 ? 1 : dl);
      for (int k = 0; k < gl * p; k++) begin e.tr = e.tr << 1; e.n++; end
      for (int k = 0; k < tl * p; k++) begin e.tr = (e.tr << 1) | 1; e.n++; end
    end
    return e;
  endfunction

  task automatic load(input logic [4:0] b, input logic [2:0] l, input logic [3:0] dl,
                      input logic [3:0] dh, input logic [3:0] g);
    code_bits = b; code_len = l; dot_len = dl; dash_len = dh; gap_len = g;
  endtask

  task automatic play(input string name, input logic [4:0] b, input logic [2:0] l,
                      input logic [3:0] dl, input logic [3:0] dh, input logic [3:0] g,
                      input int p, input exp_t e);
    int c = 0;
    q.push_back(e);
    load(b, l, dl, dh, g);
    code_valid = 1;
    tick = 0;
    step();
    code_valid = 0;
    load(5'h1f, 3'd5, 4'd9, 4'd9, 4'd9);
    while (!done && c < 3000) begin
      tick = (c % p) == p - 1;
      step();
      c++;
    end
    tick = 0;
    chk({name, "_cycles"}, c, e.n);
  endtask

  initial begin
    exp_t e;
    int c;
    step(); step();
    rst = 0;
    chk("rst_ready", code_ready, 1);
    chk("rst_beep", beep, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sym", sym_idx, 0);

    e.tr = 1024'(10'b0001000111); e.n = 10;
    play("plain", 5'b00010, 3'd2, 4'd1, 4'd3, 4'd3, 1, e);
    chk("plain_busy_after", busy, 0);
    play("gated", 5'b00010, 3'd2, 4'd1, 4'd3, 4'd3, 4, expand(5'b00010, 2, 1, 3, 3, 4));
    e.tr = 0; e.n = 0;
    play("len0", 5'b00111, 3'd0, 4'd1, 4'd3, 4'd3, 1, e);
    play("len7", 5'b10110, 3'd7, 4'd2, 4'd1, 4'd1, 1, expand(5'b10110, 7, 2, 1, 1, 1));
    e.tr = 1024'(3'b001); e.n = 3;
    play("dot0", 5'b00000, 3'd1, 4'd0, 4'd3, 4'd2, 1, e);

    // abort in the second tone: GAP c0, TONE c1-2, GAP c3, TONE c4
    load(5'b00000, 3'd2, 4'd2, 4'd3, 4'd1);
    code_valid = 1; tick = 1;
    step();
    code_valid = 0;
    for (int i = 0; i < 4; i++) step();
    chk("abort_pre_beep", beep, 1);
    chk("abort_pre_sym", sym_idx, 1);
    abort = 1;
    step();
    abort = 0;
    chk("abort_beep", beep, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sym", sym_idx, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", code_ready, 1);
    for (int i = 0; i < 5; i++) step();
    tick = 0;
    play("after_abort", 5'b00001, 3'd1, 4'd1, 4'd2, 4'd1, 1, expand(5'b00001, 1, 1, 2, 1, 1));

    // reset mid-playback suppresses done
    load(5'b00011, 3'd2, 4'd2, 4'd3, 4'd2);
    code_valid = 1; tick = 1;
    step();
    code_valid = 0;
    step(); step(); step();
    rst = 1;
    step();
    chk("rstmid_beep", beep, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_sym", sym_idx, 0);
    rst = 0;
    chk("rstmid_ready", code_ready, 1);
    for (int i = 0; i < 12; i++) step();
    chk("rstmid_idle", busy, 0);

    // abort wins over code_valid in IDLE
    load(5'b00001, 3'd1, 4'd1, 4'd1, 4'd1);
    code_valid = 1; abort = 1;
    step();
    code_valid = 0; abort = 0;
    chk("abortv_busy", busy, 0);
    chk("abortv_done", done, 0);
    step();
    chk("abortv_busy2", busy, 0);

    // back-to-back with code_valid held high
    q.push_back(expand(5'b00001, 1, 1, 2, 1, 1));
    q.push_back(expand(5'b00000, 2, 1, 3, 1, 1));
    load(5'b00001, 3'd1, 4'd1, 4'd2, 4'd1);
    code_valid = 1; tick = 1;
    step();
    load(5'b00000, 3'd2, 4'd1, 4'd3, 4'd1);
    c = 0;
    while (!done && c < 100) begin step(); c++; end
    chk("b2b_first_cycles", c, 3);
    chk("b2b_ready_in_done", code_ready, 1);
    step();
    code_valid = 0;
    chk("b2b_second_busy", busy, 1);
    c = 0;
    while (!done && c < 100) begin step(); c++; end
    chk("b2b_second_cycles", c, 4);
    step(); step();
    tick = 0;
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
